dbg_bus_ctrl: RTL and testbench

- Single-outstanding sequencer between the host debug port (AXI-lite bridge side) and the four debug segments CTL/ROM/RAM/IO.
- Accepts one 14-bit debug access; decodes the 2-bit segment and 12-bit segment address; rejects illegal addresses locally.
- Drives a one-hot req/ack handshake to the selected segment, captures read data, and returns a response with an error flag.
- Optional watchdog aborts accesses to segments that never acknowledge.

---
 rtl/dbg_bus_ctrl_pkg.sv | 48 ++++
 rtl/dbg_bus_ctrl_addr_decode.sv | 30 +++
 rtl/dbg_bus_ctrl.sv | 158 +++++++++++++++
 tb/tb_dbg_bus_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_bus_ctrl_pkg.sv
// Shared types, constants and address-legality helpers for the debug bus.
// Used by dbg_addr_decode and dbg_bus_ctrl.
package dbg_bus_ctrl_pkg;

    localparam int Dbg_timeout_w = 16;

    typedef logic [13:0] addr_t;
    typedef logic [11:0] seg_addr_t;

    typedef enum logic [1:0] {
        SEG_CTL = 2'd0,
        SEG_ROM = 2'd1,
        SEG_RAM = 2'd2,
        SEG_IO  = 2'd3
    } seg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dbg_state_t;

    localparam seg_addr_t Ctl_Id     = 12'h000;
    localparam seg_addr_t Ctl_Cfg_Lo = 12'h004;
    localparam seg_addr_t Ctl_Cfg_Hi = 12'h006;
    localparam seg_addr_t Ctl_Reg_Lo = 12'h008;
    localparam seg_addr_t Ctl_Reg_Hi = 12'h00F;
    localparam seg_addr_t Ctl_Stat   = 12'h010;

    localparam seg_addr_t Io_Mask = 12'hFF8;
    localparam seg_addr_t Io_Blk0 = 12'h000;
    localparam seg_addr_t Io_Blk1 = 12'h010;
    localparam seg_addr_t Io_Blk2 = 12'h020;

    function automatic logic ctl_addr_legal(seg_addr_t a);
        return (a == Ctl_Id)
            || (a >= Ctl_Cfg_Lo && a <= Ctl_Cfg_Hi)
            || (a >= Ctl_Reg_Lo && a <= Ctl_Reg_Hi)
            || (a == Ctl_Stat);
    endfunction

    function automatic logic io_addr_legal(seg_addr_t a);
        seg_addr_t m;
        m = a & Io_Mask;
        return (m == Io_Blk0) || (m == Io_Blk1) || (m == Io_Blk2);
    endfunction

endpackage

// File: rtl/dbg_bus_ctrl_addr_decode.sv
// Combinational debug address decoder: one-hot segment select + legal flag.
// Ports: i_addr {seg,addr}; o_sel one-hot by seg code; o_legal.
module dbg_addr_decode
    import dbg_bus_ctrl_pkg::*;
(
    input  addr_t      i_addr,
    output logic [3:0] o_sel,
    output logic       o_legal
);

    seg_t      w_seg;
    seg_addr_t w_off;

    assign w_seg = seg_t'(i_addr[13:12]);
    assign w_off = i_addr[11:0];

    always_comb begin
        o_sel   = '0;
        o_legal = 1'b0;
        o_sel[i_addr[13:12]] = 1'b1;
        unique case (w_seg)
            SEG_CTL: o_legal = ctl_addr_legal(w_off);
            SEG_ROM: o_legal = 1'b1;
            SEG_RAM: o_legal = 1'b1;
            SEG_IO:  o_legal = io_addr_legal(w_off);
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dbg_bus_ctrl.sv
// Single-outstanding debug access sequencer: host req/rsp <-> CTL/ROM/RAM/IO.
// Ports: req_* host request, rsp_* response, seg_* segment req/ack bus, busy.
// Optional watchdog abort on unacked segments: define DBG_TIMEOUT_EN.
module dbg_bus_ctrl
    import dbg_bus_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [13:0]         req_addr,
    input  logic                req_we,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [3:0]          seg_req,
    output logic [11:0]         seg_addr,
    output logic                seg_we,
    output logic [DATA_W-1:0]   seg_wdata,
    input  logic [3:0]          seg_ack,
    input  logic [4*DATA_W-1:0] seg_rdata,
    output logic                busy
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be within 1..65535");
    end

    dbg_state_t        r_state;
    logic [1:0]        r_seg;
    logic              r_legal;
    logic              r_req_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [3:0]        r_seg_req;
    logic [11:0]       r_seg_addr;
    logic              r_seg_we;
    logic [DATA_W-1:0] r_seg_wdata;

    logic [3:0]        w_sel;
    logic              w_legal;
    logic              w_ack;
    logic [DATA_W-1:0] w_slice;

`ifdef DBG_TIMEOUT_EN
    localparam logic [Dbg_timeout_w-1:0] Timeout_last =
        Dbg_timeout_w'(TIMEOUT_CYC - 1);
    logic [Dbg_timeout_w-1:0] r_cnt;
`endif

    dbg_addr_decode u_dec (
        .i_addr  (req_addr),
        .o_sel   (w_sel),
        .o_legal (w_legal)
    );

    // Only the selected segment's ack counts; stray acks are ignored.
    assign w_ack   = seg_ack[r_seg] & r_legal;
    assign w_slice = seg_rdata[32'(r_seg)*DATA_W +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_seg       <= '0;
            r_legal     <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_seg_req   <= '0;
            r_seg_addr  <= '0;
            r_seg_we    <= 1'b0;
            r_seg_wdata <= '0;
`ifdef DBG_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_seg_addr  <= req_addr[11:0];
                        r_seg_we    <= req_we;
                        r_seg_wdata <= req_wdata;
                        r_seg       <= req_addr[13:12];
                        r_legal     <= w_legal;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_legal) begin
                            r_seg_req <= w_sel;
                            r_state   <= ST_WAIT;
`ifdef DBG_TIMEOUT_EN
                            r_cnt     <= '0;
`endif
                        end else begin
                            // Illegal: answer locally, segment untouched.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_ack) begin
                        r_seg_req   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_seg_we ? '0 : w_slice;
                        r_state     <= ST_RESP;
                    end
`ifdef DBG_TIMEOUT_EN
                    else if (r_cnt == Timeout_last) begin
                        r_seg_req   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign seg_req   = r_seg_req;
    assign seg_addr  = r_seg_addr;
    assign seg_we    = r_seg_we;
    assign seg_wdata = r_seg_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dbg_bus_ctrl.sv
// Self-checking bench for dbg_bus_ctrl (random + directed scenarios).
// Build with +define+DBG_TIMEOUT_EN to also exercise the watchdog.
module tb_dbg_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [3:0]  seg_req;
    logic [11:0] seg_addr;
    logic        seg_we;
    logic [7:0]  seg_wdata;
    logic [3:0]  seg_ack;
    logic [31:0] seg_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the last access
    int          o_wait;
    int          o_lat;
    logic [3:0]  o_seen;
    logic [3:0]  o_req_after;
    bit          o_onehot_ok;
    bit          o_got;
    logic [7:0]  o_rdata;
    logic        o_err;
    logic [11:0] o_saddr;
    logic        o_swe;
    logic [7:0]  o_swd;

    always #5 clk = ~clk;

    dbg_bus_ctrl #(.DATA_W(8), .TIMEOUT_CYC(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .seg_req   (seg_req),
        .seg_addr  (seg_addr),
        .seg_we    (seg_we),
        .seg_wdata (seg_wdata),
        .seg_ack   (seg_ack),
        .seg_rdata (seg_rdata),
        .busy      (busy)
    );

    // Reference legality, straight from the address map.
    function automatic bit legal_model(logic [13:0] a);
        int s;
        int off;
        s   = int'(a[13:12]);
        off = int'(a[11:0]);
        if (s == 1 || s == 2) return 1'b1;
        if (s == 0) return off == 0 || (off >= 4 && off <= 6)
                        || (off >= 8 && off <= 16);
        return (off / 8) == 0 || (off / 8) == 2 || (off / 8) == 4;
    endfunction

    // Drive one access; ack_at = WAIT cycle index (0-based) to ack, -1 never.
    task automatic run_access(input logic [13:0] a, input logic we,
                              input logic [7:0] wd, input int ack_at,
                              input logic [7:0] rd, input bit spur);
        int         k;
        logic [1:0] s;
        logic [1:0] sp;
        s  = a[13:12];
        sp = s + 2'd1;
        k  = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_we    = we;
        req_wdata = wd;
        o_wait = 0; o_seen = '0; o_onehot_ok = 1'b1; o_got = 1'b0;
        @(negedge clk);
        o_lat = 1;
        req_valid = 1'b0;
        o_saddr = seg_addr; o_swe = seg_we; o_swd = seg_wdata;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid) begin
                o_got = 1'b1;
                break;
            end
            seg_rdata = $urandom;
            seg_ack   = '0;
            if (seg_req != 4'b0) begin
                o_wait++;
                o_seen |= seg_req;
                if (!$onehot(seg_req)) o_onehot_ok = 1'b0;
                if (spur && k == 1) seg_ack[sp] = 1'b1;
                if (k == ack_at) begin
                    seg_ack[s] = 1'b1;
                    seg_rdata[int'(s)*8 +: 8] = rd;
                end
                k++;
            end
            @(negedge clk);
            o_lat++;
        end
        seg_ack     = '0;
        o_rdata     = rsp_rdata;
        o_err       = rsp_err;
        o_req_after = seg_req;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_addr = '0; req_we = 0; req_wdata = '0;
        rsp_ready = 0; seg_ack = '0; seg_rdata = '0;
        #23;
        n_checks++;
        if ({req_ready, busy, rsp_valid, rsp_err, rsp_rdata, seg_req}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_outs: rdy=%b busy=%b v=%b e=%b rd=%h req=%b want rdy=1 rest 0",
                     req_ready, busy, rsp_valid, rsp_err, rsp_rdata, seg_req);
        end
        n_checks++;
        if ({seg_addr, seg_we, seg_wdata} !== 21'h0) begin
            n_fail++;
            $display("FAIL reset_seg: addr=%h we=%b wd=%h want 0",
                     seg_addr, seg_we, seg_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: rdy=%b busy=%b want 1/0", req_ready, busy);
        end
    endtask

    task automatic test_read_rom();
        run_access(14'h1123, 1'b0, 8'h00, 0, 8'hA5, 1'b0);
        n_checks++;
        if (o_seen !== 4'b0010 || o_saddr !== 12'h123 || o_wait != 1) begin
            n_fail++;
            $display("FAIL rom_req: seg_req=%b addr=%h wait=%0d want 0010/123/1",
                     o_seen, o_saddr, o_wait);
        end
        n_checks++;
        if (!o_got || o_lat != 2) begin
            n_fail++;
            $display("FAIL rom_latency: got=%b lat=%0d want 1/2", o_got, o_lat);
        end
        n_checks++;
        if (o_rdata !== 8'hA5 || o_err !== 1'b0 || o_req_after !== 4'b0) begin
            n_fail++;
            $display("FAIL rom_rsp: rd=%h err=%b req=%b want a5/0/0000",
                     o_rdata, o_err, o_req_after);
        end
        accept_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 8'h0) begin
            n_fail++;
            $display("FAIL rom_idle: v=%b rdy=%b rd=%h want 0/1/00",
                     rsp_valid, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_write_io();
        run_access(14'h3012, 1'b1, 8'h3C, 4, 8'hEE, 1'b1);
        n_checks++;
        if (o_seen !== 4'b1000 || o_wait != 5 || !o_onehot_ok) begin
            n_fail++;
            $display("FAIL io_req: seg_req=%b wait=%0d onehot=%b want 1000/5/1",
                     o_seen, o_wait, o_onehot_ok);
        end
        n_checks++;
        if (o_swd !== 8'h3C || o_swe !== 1'b1 || o_saddr !== 12'h012) begin
            n_fail++;
            $display("FAIL io_seg: wd=%h we=%b addr=%h want 3c/1/012",
                     o_swd, o_swe, o_saddr);
        end
        n_checks++;
        if (!o_got || o_rdata !== 8'h0 || o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL io_rsp: got=%b rd=%h err=%b want 1/00/0",
                     o_got, o_rdata, o_err);
        end
        accept_rsp();
    endtask

    task automatic test_illegal();
        logic [13:0] addrs [2];
        addrs[0] = 14'h0007;
        addrs[1] = 14'h3030;
        foreach (addrs[i]) begin
            run_access(addrs[i], 1'b0, 8'h00, 0, 8'h77, 1'b0);
            n_checks++;
            if (o_seen !== 4'b0 || o_wait != 0 || o_lat != 1) begin
                n_fail++;
                $display("FAIL illegal_noreq %h: seg_req=%b lat=%0d want 0000/1",
                         addrs[i], o_seen, o_lat);
            end
            n_checks++;
            if (!o_got || o_err !== 1'b1 || o_rdata !== 8'h0) begin
                n_fail++;
                $display("FAIL illegal_rsp %h: got=%b err=%b rd=%h want 1/1/00",
                         addrs[i], o_got, o_err, o_rdata);
            end
            accept_rsp();
        end
    endtask

    task automatic test_backpressure();
        bit stable;
        run_access(14'h2040, 1'b0, 8'h00, 1, 8'h96, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            req_addr  = 14'h1ABC;
            req_we    = 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h96 || rsp_err !== 1'b0
                || req_ready !== 1'b0 || busy !== 1'b1 || seg_req !== 4'b0)
                stable = 1'b0;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL bp_stable: v=%b rd=%h err=%b rdy=%b want 1/96/0/0",
                     rsp_valid, rsp_rdata, rsp_err, req_ready);
        end
        accept_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_idle: v=%b rdy=%b busy=%b want 0/1/0",
                     rsp_valid, req_ready, busy);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (seg_req !== 4'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_queue: seg_req=%b v=%b want 0000/0",
                     seg_req, rsp_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [13:0] a;
            logic        we;
            logic [7:0]  wd;
            logic [7:0]  rd;
            int          dly;
            bit          lg;
            a[13:12] = 2'($urandom_range(0, 3));
            a[11:0]  = ($urandom_range(0, 3) != 0)
                       ? 12'($urandom_range(0, 47)) : 12'($urandom);
            we  = 1'($urandom);
            wd  = 8'($urandom);
            rd  = 8'($urandom);
            dly = $urandom_range(0, 5);
            lg  = legal_model(a);
            run_access(a, we, wd, dly, rd, 1'($urandom));
            n_checks++;
            if (o_seen !== (lg ? (4'b1 << a[13:12]) : 4'b0)
                || o_wait != (lg ? dly + 1 : 0) || !o_onehot_ok) begin
                n_fail++;
                $display("FAIL rnd_req %h: seg_req=%b wait=%0d want legal=%b dly=%0d",
                         a, o_seen, o_wait, lg, dly);
            end
            n_checks++;
            if (!o_got || o_err !== !lg || o_rdata !== ((lg && !we) ? rd : 8'h0)
                || o_lat != (lg ? dly + 2 : 1)) begin
                n_fail++;
                $display("FAIL rnd_rsp %h we=%b: err=%b rd=%h lat=%0d want err=%b rd=%h",
                         a, we, o_err, o_rdata, o_lat, !lg,
                         (lg && !we) ? rd : 8'h0);
            end
            n_checks++;
            if (o_saddr !== a[11:0] || o_swe !== we || o_swd !== wd) begin
                n_fail++;
                $display("FAIL rnd_seg %h: addr=%h we=%b wd=%h want %h/%b/%h",
                         a, o_saddr, o_swe, o_swd, a[11:0], we, wd);
            end
            accept_rsp();
        end
    endtask

`ifdef DBG_TIMEOUT_EN
    task automatic test_timeout();
        run_access(14'h2100, 1'b0, 8'h00, -1, 8'h11, 1'b0);
        n_checks++;
        if (!o_got || o_wait != 8 || o_err !== 1'b1 || o_rdata !== 8'h0) begin
            n_fail++;
            $display("FAIL timeout_abort: got=%b wait=%0d err=%b rd=%h want 1/8/1/00",
                     o_got, o_wait, o_err, o_rdata);
        end
        accept_rsp();
        run_access(14'h2100, 1'b0, 8'h00, 7, 8'h5A, 1'b0);
        n_checks++;
        if (!o_got || o_wait != 8 || o_err !== 1'b0 || o_rdata !== 8'h5A) begin
            n_fail++;
            $display("FAIL timeout_ackwins: got=%b wait=%0d err=%b rd=%h want 1/8/0/5a",
                     o_got, o_wait, o_err, o_rdata);
        end
        accept_rsp();
    endtask
`endif

    task automatic test_reset_in_wait();
        bit quiet;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 14'h2040;
        req_we    = 1'b0;
        seg_ack   = '0;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seg_req !== 4'b0100 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_pre: seg_req=%b busy=%b want 0100/1", seg_req, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_req !== 4'b0 || busy !== 1'b0 || rsp_valid !== 1'b0
            || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_async: seg_req=%b busy=%b v=%b rdy=%b want 0/0/0/1",
                     seg_req, busy, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            seg_ack = 4'b0100;
            @(negedge clk);
            if (rsp_valid !== 1'b0 || seg_req !== 4'b0 || req_ready !== 1'b1)
                quiet = 1'b0;
        end
        seg_ack = '0;
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL rstw_quiet: v=%b seg_req=%b rdy=%b want 0/0000/1",
                     rsp_valid, seg_req, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_read_rom();
        test_write_io();
        test_illegal();
        test_backpressure();
        test_random();
`ifdef DBG_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
